// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit for the RV32EC core.
// Shifts an accumulator by Step or 1 bit per cycle, so no full barrel shifter is needed.
module shift_sequencer #(
    parameter int Width      = 32,
    parameter int ShamtWidth = 5,
    parameter int Step       = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            CtrlShiftOp,
    input  logic [Width-1:0]      Rs1,
    input  logic [ShamtWidth-1:0] Shamt,
    output logic                  Busy,
    output logic                  Done,
    output logic [Width-1:0]      Rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_BAD = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    localparam logic [ShamtWidth-1:0] STEP_C = ShamtWidth'(Step);
    localparam logic [ShamtWidth-1:0] ONE_C  = ShamtWidth'(1);

    state_t                r_state;
    logic [Width-1:0]      r_acc;
    logic [ShamtWidth-1:0] r_count;
    logic [1:0]            r_op;

    state_t                w_state_nxt;
    logic [Width-1:0]      w_acc_nxt;
    logic [ShamtWidth-1:0] w_count_nxt;
    logic [1:0]            w_op_nxt;
    logic                  w_accept;
    logic                  w_big;
    logic [ShamtWidth-1:0] w_k;
    logic [Width-1:0]      w_acc_step;
    logic [Width-1:0]      w_acc_one;

    // Only two fixed shift distances exist, so each is just wiring.
    always_comb begin
        w_acc_step = r_acc;
        w_acc_one  = r_acc;
        unique case (r_op)
            OP_SLL: begin
                w_acc_step = r_acc << Step;
                w_acc_one  = r_acc << 1;
            end
            OP_SRL: begin
                w_acc_step = r_acc >> Step;
                w_acc_one  = r_acc >> 1;
            end
            default: begin
                w_acc_step = $signed(r_acc) >>> Step;
                w_acc_one  = $signed(r_acc) >>> 1;
            end
        endcase
    end

    assign w_accept = Start && (r_state != SHIFT);
    assign w_big    = (r_count >= STEP_C);
    assign w_k      = w_big ? STEP_C : ONE_C;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        unique case (r_state)
            SHIFT: begin
                w_acc_nxt   = w_big ? w_acc_step : w_acc_one;
                w_count_nxt = r_count - w_k;
                if (w_count_nxt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    w_acc_nxt   = Rs1;
                    w_count_nxt = Shamt;
                    w_op_nxt    = CtrlShiftOp;
                    if ((Shamt == '0) || (CtrlShiftOp == OP_BAD)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_op    <= OP_SLL;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign Busy = (r_state == SHIFT);
    assign Done = (r_state == DONE);
    assign Rd   = r_acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (Width=32, Step=4).
// Expected results and cycle counts are hand-computed constants.
module tb_shift_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  CtrlShiftOp;
    logic [31:0] Rs1;
    logic [4:0]  Shamt;
    logic        Busy;
    logic        Done;
    logic [31:0] Rd;

    int n_cmp;
    int n_err;

    shift_sequencer #(
        .Width(32),
        .ShamtWidth(5),
        .Step(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .CtrlShiftOp(CtrlShiftOp),
        .Rs1(Rs1),
        .Shamt(Shamt),
        .Busy(Busy),
        .Done(Done),
        .Rd(Rd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] rs1,
                         input logic [4:0] sh, input int exp_busy,
                         input logic [31:0] exp_rd, input string tag);
        int nb;
        CtrlShiftOp = op;
        Rs1 = rs1;
        Shamt = sh;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        nb = 0;
        while (Busy && nb < 100) begin
            nb++;
            tick();
        end
        chk(32'(nb), 32'(exp_busy), {tag, "_busy"});
        chk({31'b0, Done}, 32'd1, {tag, "_done"});
        chk(Rd, exp_rd, {tag, "_rd"});
        tick();
        chk({30'b0, Busy, Done}, 32'd0, {tag, "_idle"});
        chk(Rd, exp_rd, {tag, "_hold"});
    endtask

    initial begin
        int nb;
        int pulses;
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        Start = 1'b0;
        CtrlShiftOp = 2'b00;
        Rs1 = '0;
        Shamt = '0;
        tick();
        tick();
        chk({30'b0, Busy, Done}, 32'd0, "rst_flags");
        chk(Rd, 32'h0, "rst_rd");
        Reset = 1'b0;
        tick();

        do_op(2'b00, 32'h0000_0001, 5'd31, 10, 32'h8000_0000, "sll31");
        do_op(2'b11, 32'h8000_0000, 5'd4, 1, 32'hF800_0000, "sra4");
        do_op(2'b11, 32'h8000_0000, 5'd31, 10, 32'hFFFF_FFFF, "sra31");
        do_op(2'b10, 32'h8000_0000, 5'd5, 2, 32'h0400_0000, "srl5");
        do_op(2'b10, 32'h0000_00F0, 5'd3, 3, 32'h0000_001E, "srl3");
        do_op(2'b00, 32'h0000_00FF, 5'd8, 2, 32'h0000_FF00, "sll8");
        do_op(2'b11, 32'h7000_0000, 5'd1, 1, 32'h3800_0000, "sra1pos");
        do_op(2'b00, 32'h1234_5678, 5'd0, 0, 32'h1234_5678, "sh0");
        do_op(2'b01, 32'hDEAD_BEEF, 5'd7, 0, 32'hDEAD_BEEF, "op01");

        // Start mid-shift must be ignored
        CtrlShiftOp = 2'b00;
        Rs1 = 32'h0000_0001;
        Shamt = 5'd31;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        nb = 0;
        while (Busy && nb < 100) begin
            if (nb == 3) begin
                Start = 1'b1;
                CtrlShiftOp = 2'b10;
                Rs1 = 32'hFFFF_0000;
                Shamt = 5'd1;
            end else begin
                Start = 1'b0;
            end
            nb++;
            tick();
        end
        Start = 1'b0;
        chk(32'(nb), 32'd10, "ign_busy");
        chk({31'b0, Done}, 32'd1, "ign_done");
        chk(Rd, 32'h8000_0000, "ign_rd");
        tick();

        // Back-to-back through DONE
        CtrlShiftOp = 2'b00;
        Rs1 = 32'h0000_0001;
        Shamt = 5'd4;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk({30'b0, Busy, Done}, 32'd2, "b2b_sh1");
        tick();
        chk({30'b0, Busy, Done}, 32'd1, "b2b_done1");
        chk(Rd, 32'h0000_0010, "b2b_rd1");
        Rs1 = 32'h0000_0003;
        Shamt = 5'd2;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk({30'b0, Busy, Done}, 32'd2, "b2b_nogap");
        tick();
        chk({30'b0, Busy, Done}, 32'd2, "b2b_sh2");
        tick();
        chk({30'b0, Busy, Done}, 32'd1, "b2b_done2");
        chk(Rd, 32'h0000_000C, "b2b_rd2");
        tick();

        // Reset in the third SHIFT cycle of a 31-bit shift
        CtrlShiftOp = 2'b00;
        Rs1 = 32'h0000_0001;
        Shamt = 5'd31;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk({31'b0, Busy}, 32'd1, "mid_busy");
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk({30'b0, Busy, Done}, 32'd0, "mid_rst_flags");
        chk(Rd, 32'h0, "mid_rst_rd");
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done || Busy) pulses++;
            tick();
        end
        chk(32'(pulses), 32'd0, "mid_no_done");
        do_op(2'b10, 32'h8000_0000, 5'd5, 2, 32'h0400_0000, "after_rst");

        // Reset wins over a simultaneous Start
        CtrlShiftOp = 2'b00;
        Rs1 = 32'hAAAA_5555;
        Shamt = 5'd5;
        Start = 1'b1;
        Reset = 1'b1;
        tick();
        Start = 1'b0;
        Reset = 1'b0;
        chk({30'b0, Busy, Done}, 32'd0, "rs_flags0");
        tick();
        chk({30'b0, Busy, Done}, 32'd0, "rs_flags1");
        chk(Rd, 32'h0, "rs_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
